stat_seq_ctrl: RTL and testbench
================================

# stat_seq_ctrl

Sequencer that streams a batch of signed 16-bit samples through the shared combinational statistical unit and reports batch mean, maximum and minimum. It owns the unit's operand and op-select inputs, running one max step and one min step per sample. It accumulates the sum internally and finishes with a multi-cycle divider. It sits between the keypad/sample buffer (producer) and the result display mux (consumer).

## Interface
- CNT_W, 8: width of the batch length; maximum batch size is 2^CNT_W − 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a batch; sampled only in IDLE.
- count  in  CNT_W  batch length, latched on start.
- s_valid  in  1  sample valid.
- s_data  in  16 signed  sample.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- su_a  out  16 signed  statistical unit operand a.
- su_b  out  16 signed  statistical unit operand b.
- su_op_sel  out  3  statistical unit op: 001 max, 010 min, 111 idle (unit returns 0).
- su_result  in  32 signed  statistical unit result; combinational from su_a/su_b/su_op_sel.
- m_valid  out  1  results valid.
- m_ready  in  1  consumer accepts results.
- mean_out  out  16 signed  sum/count, truncated toward zero.
- max_out  out  16 signed  batch maximum.
- min_out  out  16 signed  batch minimum.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse when start is seen with count == 0.

## Operation
- States: IDLE, WAIT_SAMPLE, DO_MAX, DO_MIN, DIVIDE, DONE.
- IDLE, start=1, count≠0: latch count, clear sum and sample index, go to WAIT_SAMPLE.
- IDLE, start=1, count=0: pulse err, stay in IDLE.
- start outside IDLE is ignored.
- WAIT_SAMPLE: s_ready=1. On handshake, add s_data, sign-extended, into the (16+CNT_W)-bit sum and store it as cur.
- First sample (index 0): load max and min directly with s_data. Go to DIVIDE if count==1, else stay in WAIT_SAMPLE.
- Later samples: go to DO_MAX.
- DO_MAX: su_a=cur, su_b=max, su_op_sel=001; max ← su_result[15:0]. Go to DO_MIN.
- DO_MIN: su_a=cur, su_b=min, su_op_sel=010; min ← su_result[15:0]. If this was the last sample go to DIVIDE, else WAIT_SAMPLE.
- All other states: su_op_sel=111, su_a=su_b=0.
- DIVIDE: restoring unsigned divide of |sum| by count, one quotient bit per cycle, exactly 16+CNT_W cycles. The quotient is negated if sum<0. Truncation is toward zero, so −11/2 = −5.
- DONE: m_valid=1; mean_out/max_out/min_out held stable until m_ready. On the m_valid && m_ready cycle go to IDLE.
- max_out/min_out/mean_out keep their last values in IDLE until the next DONE.

## Timing
- Reset: all state → IDLE. s_ready, m_valid, busy, err = 0; mean_out, max_out, min_out, su_a, su_b = 0; su_op_sel = 111.
- Reset mid-batch aborts with no output. A sample offered on the reset cycle is not accepted.
- Per sample after the first: 3 cycles minimum (accept, DO_MAX, DO_MIN). s_ready is low in DO_MAX/DO_MIN.
- Producer stalls (s_valid low) hold the block in WAIT_SAMPLE indefinitely.
- Last sample accepted at edge E, count>1: DIVIDE occupies E+3..E+2+(16+CNT_W); m_valid rises after edge E+3+(16+CNT_W), which is E+27 for CNT_W=8.
- Last sample accepted at edge E, count=1: m_valid rises after E+1+(16+CNT_W), which is E+25.
- Consumer backpressure: m_valid stays high with stable data for any number of cycles.
- busy deasserts the cycle after the result handshake.
- start on that same handshake cycle is ignored. The earliest new start is the following cycle.

## Configuration
- STAT_SEQ_RANGE_EN defined: adds output port range_out (out, 17 signed) = max_out − min_out. It is computed at full 17-bit width, is registered in DONE alongside the other results, and resets to 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- count=3, samples 10, −4, 7 → m_valid with mean_out=4, max_out=10, min_out=−4 (range_out=14 when enabled). su_op_sel shows 001 then 010 after samples 2 and 3.
- count=2, samples −5, −6 → mean_out=−5 (toward zero), max_out=−5, min_out=−6.
- count=1, sample 32767 → mean_out=max_out=min_out=32767; m_valid 25 cycles after acceptance.
- count=0 with start → err high exactly one cycle; busy stays 0; no s_ready.
- count=255, all samples −32768 with random s_valid gaps, m_ready held low 10 cycles → mean_out=−32768; outputs stable during the stall; IDLE the cycle after m_ready.
- rst_n low for one cycle after the 2nd of 4 samples → all outputs at reset values. A fresh batch of count=2, samples 1, 2 gives mean_out=1, max_out=2, min_out=1.

Source files
------------

// File: rtl/stat_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stat_seq_ctrl
// Description : Streams a sample batch through the shared statistical unit
//               and reports mean, maximum and minimum.
//               Optional define STAT_SEQ_RANGE_EN adds range_out.
// Revision    : 1.0 - initial release
// ============================================================================
module stat_seq_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    count,
    input  logic                s_valid,
    input  logic signed [15:0]  s_data,
    output logic                s_ready,
    output logic signed [15:0]  su_a,
    output logic signed [15:0]  su_b,
    output logic [2:0]          su_op_sel,
    input  logic signed [31:0]  su_result,
    output logic                m_valid,
    input  logic                m_ready,
    output logic signed [15:0]  mean_out,
    output logic signed [15:0]  max_out,
    output logic signed [15:0]  min_out,
`ifdef STAT_SEQ_RANGE_EN
    output logic signed [16:0]  range_out,
`endif
    output logic                busy,
    output logic                err
);

    localparam int c_sum_w  = 16 + CNT_W;
    localparam int c_dcnt_w = $clog2(c_sum_w + 1);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_wait    = 3'd1;
    localparam logic [2:0] c_do_max  = 3'd2;
    localparam logic [2:0] c_do_min  = 3'd3;
    localparam logic [2:0] c_divide  = 3'd4;
    localparam logic [2:0] c_done    = 3'd5;

    localparam logic [2:0] c_op_max  = 3'b001;
    localparam logic [2:0] c_op_min  = 3'b010;
    localparam logic [2:0] c_op_idle = 3'b111;

    logic [2:0]                  r_state;
    logic [CNT_W-1:0]            r_count;
    logic [CNT_W-1:0]            r_idx;
    logic signed [c_sum_w-1:0]   r_sum;
    logic signed [15:0]          r_cur;
    logic signed [15:0]          r_max;
    logic signed [15:0]          r_min;
    logic [c_sum_w-1:0]          r_quo;
    logic [CNT_W-1:0]            r_rem;
    logic [c_dcnt_w-1:0]         r_div_cnt;

    logic [c_sum_w-1:0]          w_abs_sum;
    logic                        w_first;
    logic [c_sum_w-1:0]          w_dvd;
    logic [CNT_W-1:0]            w_rem_in;
    logic [CNT_W:0]              w_trial;
    logic [CNT_W:0]              w_diff;
    logic                        w_ge;
    logic [CNT_W-1:0]            w_rem_nxt;
    logic [c_sum_w-1:0]          w_mean_full;
    logic                        w_unused;

    // The first divide step pulls the dividend straight from |sum| and
    // starts from a zero remainder, so no separate load cycle is needed.
    assign w_abs_sum   = r_sum[c_sum_w-1] ? (~r_sum + c_sum_w'(1)) : r_sum;
    assign w_first     = (r_div_cnt == '0);
    assign w_dvd       = w_first ? w_abs_sum : r_quo;
    assign w_rem_in    = w_first ? '0 : r_rem;
    assign w_trial     = {w_rem_in, w_dvd[c_sum_w-1]};
    assign w_diff      = w_trial - {1'b0, r_count};
    assign w_ge        = (w_trial >= {1'b0, r_count});
    assign w_rem_nxt   = w_ge ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
    assign w_mean_full = r_sum[c_sum_w-1] ? (~r_quo + c_sum_w'(1)) : r_quo;
    assign w_unused    = ^{su_result[31:16], w_mean_full[c_sum_w-1:16], w_diff[CNT_W]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_count   <= '0;
            r_idx     <= '0;
            r_sum     <= '0;
            r_cur     <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_div_cnt <= '0;
            s_ready   <= 1'b0;
            su_a      <= '0;
            su_b      <= '0;
            su_op_sel <= c_op_idle;
            m_valid   <= 1'b0;
            mean_out  <= '0;
            max_out   <= '0;
            min_out   <= '0;
`ifdef STAT_SEQ_RANGE_EN
            range_out <= '0;
`endif
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        if (count == '0) begin
                            err <= 1'b1;
                        end else begin
                            r_count <= count;
                            r_idx   <= '0;
                            r_sum   <= '0;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
                            r_state <= c_wait;
                        end
                    end
                end
                c_wait: begin
                    if (s_valid) begin
                        r_sum <= r_sum + {{CNT_W{s_data[15]}}, s_data};
                        r_cur <= s_data;
                        r_idx <= r_idx + CNT_W'(1);
                        if (r_idx == '0) begin
                            r_max <= s_data;
                            r_min <= s_data;
                            if (r_count == CNT_W'(1)) begin
                                s_ready   <= 1'b0;
                                r_div_cnt <= '0;
                                r_state   <= c_divide;
                            end
                        end else begin
                            s_ready   <= 1'b0;
                            su_a      <= s_data;
                            su_b      <= r_max;
                            su_op_sel <= c_op_max;
                            r_state   <= c_do_max;
                        end
                    end
                end
                c_do_max: begin
                    r_max     <= su_result[15:0];
                    su_a      <= r_cur;
                    su_b      <= r_min;
                    su_op_sel <= c_op_min;
                    r_state   <= c_do_min;
                end
                c_do_min: begin
                    r_min     <= su_result[15:0];
                    su_a      <= '0;
                    su_b      <= '0;
                    su_op_sel <= c_op_idle;
                    if (r_idx == r_count) begin
                        r_div_cnt <= '0;
                        r_state   <= c_divide;
                    end else begin
                        s_ready <= 1'b1;
                        r_state <= c_wait;
                    end
                end
                c_divide: begin
                    // One quotient bit per step, then a final cycle applies the sign.
                    if (r_div_cnt == c_dcnt_w'(c_sum_w)) begin
                        mean_out <= w_mean_full[15:0];
                        max_out  <= r_max;
                        min_out  <= r_min;
`ifdef STAT_SEQ_RANGE_EN
                        range_out <= {r_max[15], r_max} - {r_min[15], r_min};
`endif
                        m_valid  <= 1'b1;
                        r_state  <= c_done;
                    end else begin
                        r_quo     <= {w_dvd[c_sum_w-2:0], w_ge};
                        r_rem     <= w_rem_nxt;
                        r_div_cnt <= r_div_cnt + c_dcnt_w'(1);
                    end
                end
                c_done: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stat_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stat_seq_ctrl
// Description : Directed scoreboard bench for stat_seq_ctrl with a behavioural
//               statistical unit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stat_seq_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [7:0]         count;
    logic               s_valid;
    logic signed [15:0] s_data;
    logic               s_ready;
    logic signed [15:0] su_a;
    logic signed [15:0] su_b;
    logic [2:0]         su_op_sel;
    logic signed [31:0] su_result;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] mean_out;
    logic signed [15:0] max_out;
    logic signed [15:0] min_out;
`ifdef STAT_SEQ_RANGE_EN
    logic signed [16:0] range_out;
`endif
    logic               busy;
    logic               err;

    typedef struct {
        int mean;
        int mx;
        int mn;
    } exp_t;

    exp_t exp_q[$];
    int   smp[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    stat_seq_ctrl #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .su_a      (su_a),
        .su_b      (su_b),
        .su_op_sel (su_op_sel),
        .su_result (su_result),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .mean_out  (mean_out),
        .max_out   (max_out),
        .min_out   (min_out),
`ifdef STAT_SEQ_RANGE_EN
        .range_out (range_out),
`endif
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the shared statistical unit
    always_comb begin
        su_result = '0;
        case (su_op_sel)
            3'b001:  su_result = (su_a > su_b) ? 32'(su_a) : 32'(su_b);
            3'b010:  su_result = (su_a < su_b) ? 32'(su_a) : 32'(su_b);
            default: su_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_mean"}, mean_out, 0);
        chk({tag, "_max"}, max_out, 0);
        chk({tag, "_min"}, min_out, 0);
        chk({tag, "_su_a"}, su_a, 0);
        chk({tag, "_su_b"}, su_b, 0);
        chk({tag, "_op"}, su_op_sel, 7);
`ifdef STAT_SEQ_RANGE_EN
        chk({tag, "_range"}, range_out, 0);
`endif
    endtask

    // Reference model: mean truncates toward zero like SV integer division.
    task automatic push_expect();
        exp_t e;
        int   sum;
        sum = 0;
        e.mx = -40000;
        e.mn = 40000;
        foreach (smp[i]) begin
            sum += smp[i];
            if (smp[i] > e.mx) e.mx = smp[i];
            if (smp[i] < e.mn) e.mn = smp[i];
        end
        e.mean = sum / smp.size();
        exp_q.push_back(e);
    endtask

    task automatic start_batch(input int n);
        start = 1'b1;
        count = 8'(n);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_sample(input int v, input int gap);
        int n;
        n = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = 16'(v);
        while (1) begin
            @(negedge clk);
            if (s_ready || n > 100) break;
            n++;
        end
        chk("s_ready_wait", s_ready, 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        s_valid = 1'b0;
    endtask

    task automatic wait_result(input int stall, input int exp_lat, input bit start_on_hs);
        int   n;
        exp_t e;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (m_valid || n > 400) break;
            n++;
        end
        chk("m_valid_wait", m_valid, 1);
        if (exp_lat >= 0) chk("latency", cyc - acc_cyc, exp_lat);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        chk("mean", mean_out, e.mean);
        chk("max", max_out, e.mx);
        chk("min", min_out, e.mn);
`ifdef STAT_SEQ_RANGE_EN
        chk("range", range_out, e.mx - e.mn);
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", m_valid, 1);
            chk("stall_mean", mean_out, e.mean);
            chk("stall_max", max_out, e.mx);
            chk("stall_min", min_out, e.mn);
        end
        m_ready = 1'b1;
        if (start_on_hs) begin
            start = 1'b1;
            count = 8'd1;
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_valid", m_valid, 0);
        chk("post_hs_ready", s_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        count   = '0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Batch of three with unit op-select observation
        smp = '{10, -4, 7};
        push_expect();
        start_batch(3);
        chk("busy_start", busy, 1);
        send_sample(10, 0);
        send_sample(-4, 1);
        @(negedge clk);
        chk("op_max_s2", su_op_sel, 1);
        chk("su_a_max_s2", su_a, -4);
        chk("su_b_max_s2", su_b, 10);
        chk("s_ready_do_max", s_ready, 0);
        @(negedge clk);
        chk("op_min_s2", su_op_sel, 2);
        chk("su_b_min_s2", su_b, 10);
        send_sample(7, 0);
        @(negedge clk);
        chk("op_max_s3", su_op_sel, 1);
        chk("su_b_max_s3", su_b, 10);
        @(negedge clk);
        chk("op_min_s3", su_op_sel, 2);
        chk("su_b_min_s3", su_b, -4);
        wait_result(0, 27, 1'b0);

        // Negative mean truncates toward zero
        smp = '{-5, -6};
        push_expect();
        start_batch(2);
        send_sample(-5, 0);
        send_sample(-6, 2);
        wait_result(0, 27, 1'b0);

        // Single sample at positive limit
        smp = '{32767};
        push_expect();
        start_batch(1);
        send_sample(32767, 0);
        wait_result(0, 25, 1'b0);

        // Zero count raises a single-cycle error
        start = 1'b1;
        count = 8'd0;
        @(posedge clk);
        #1 start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        chk("err_clear", err, 0);
        chk("err_busy2", busy, 0);

        // Full-size batch at negative limit, gaps and consumer stall
        smp.delete();
        for (int i = 0; i < 255; i++) smp.push_back(-32768);
        push_expect();
        start_batch(255);
        for (int i = 0; i < 255; i++) send_sample(-32768, $urandom_range(0, 2));
        wait_result(10, 27, 1'b1);

        // Reset in the middle of a batch
        start_batch(4);
        send_sample(100, 0);
        send_sample(-100, 0);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'sd5;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        s_valid = 1'b0;
        @(posedge clk);
        #1;

        smp = '{1, 2};
        push_expect();
        start_batch(2);
        send_sample(1, 0);
        send_sample(2, 0);
        wait_result(0, 27, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
